// File: rtl/spi_pkg.sv
// Shared SPI front-end definitions: transfer width, frame FSM states and the
// command byte values the downstream decoder already recognises.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [SPI_BYTE_W-1:0] CMD_LOAD_A = 8'h10;
    localparam logic [SPI_BYTE_W-1:0] CMD_LOAD_B = 8'h11;
    localparam logic [SPI_BYTE_W-1:0] CMD_START  = 8'h20;
    localparam logic [SPI_BYTE_W-1:0] CMD_READ   = 8'h30;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings one raw asynchronous SPI line into the clk domain through a flop
// chain and reports its synchronized level plus single-cycle rise/fall flags.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Synchronizer chain plus a delayed copy of its last stage for edge detect.
    // NOTE: every flop here is written with <= so all stages sample the value
    // from before the clock edge; blocking writes would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_byte_frontend.sv
// SPI mode-0 slave front end: oversamples sclk/mosi/cs_n, deserializes
// MSB-first bytes into rx_valid pulses tagged with frame markers, and shifts a
// one-deep transmit buffer out on miso.
module spi_byte_frontend
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BYTE_W      = SPI_BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_first,
    output logic              frame_start,
    output logic              frame_end,
    output logic              rx_abort,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_full,
    output logic              tx_underrun
);

    localparam int               CNT_W    = $clog2(BYTE_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);
    localparam logic [1:0]       SETTLE   = 2'(SYNC_STAGES);

    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic cs_level, cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk), .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi), .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs_n), .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    // Only the mosi level and the sclk edges matter to the datapath.
    logic unused_edges;
    assign unused_edges = ^{sclk_level, mosi_rise, mosi_fall};

    state_t             state, state_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BYTE_W-1:0]  rx_shift, tx_shift, tx_buf;
    logic               first_pending, byte_done;
    logic [1:0]         settle_cnt;
    logic               armed;
    logic               start_evt, end_evt, bit_evt, shift_evt, reload_evt;
    logic               drain, tx_accept;

    // After reset the cs_n chain holds its idle value until real samples reach
    // the end; only arm frame detection once a genuine high level has been seen,
    // so a cs_n still low from before reset cannot fake a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 2'd0;
            armed      <= 1'b0;
        end else if (settle_cnt != SETTLE) begin
            settle_cnt <= settle_cnt + 2'd1;
        end else if (cs_level) begin
            armed <= 1'b1;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and per-cycle event decode; chip-select wins over sclk.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        start_evt  = 1'b0;
        end_evt    = 1'b0;
        bit_evt    = 1'b0;
        shift_evt  = 1'b0;
        reload_evt = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    state_next = ACTIVE;
                    start_evt  = 1'b1;
                    reload_evt = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    end_evt    = 1'b1;
                end else if (sclk_rise) begin
                    bit_evt = 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt != '0) shift_evt  = 1'b1;
                    else               reload_evt = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A drain and a load in the same cycle: the drain takes the old byte and
    // the new one refills the buffer.
    assign drain     = reload_evt & tx_full;
    assign tx_accept = tx_load & (~tx_full | drain);

    // Receive/transmit datapath and the single-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            first_pending <= 1'b0;
            byte_done     <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_first      <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            rx_abort      <= 1'b0;
            tx_full       <= 1'b0;
            tx_underrun   <= 1'b0;
        end else begin
            frame_start <= start_evt;
            frame_end   <= end_evt;
            rx_abort    <= end_evt && (bit_cnt != '0);
            rx_valid    <= byte_done;
            byte_done   <= bit_evt && (bit_cnt == LAST_BIT);

            if (byte_done) begin
                rx_data       <= rx_shift;
                rx_first      <= first_pending;
                first_pending <= 1'b0;
            end
            if (bit_evt) begin
                rx_shift <= {rx_shift[BYTE_W-2:0], mosi_level};
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
            if (start_evt) begin
                bit_cnt       <= '0;
                first_pending <= 1'b1;
                tx_underrun   <= 1'b0;
            end
            if (end_evt) begin
                bit_cnt <= '0;
            end

            if (reload_evt) begin
                tx_shift <= tx_full ? tx_buf : '0;
                if (!tx_full) tx_underrun <= 1'b1;
            end else if (shift_evt) begin
                tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            end

            if (tx_accept)  tx_full <= 1'b1;
            else if (drain) tx_full <= 1'b0;
        end
    end

    // Transmit buffer storage.
    // NOTE: no reset here; tx_full is reset and guards every read of tx_buf.
    always_ff @(posedge clk) begin
        if (tx_accept) tx_buf <= tx_data;
    end

    assign miso = (state == ACTIVE) & tx_shift[BYTE_W-1];

endmodule

// File: tb/tb_spi_byte_frontend.sv
// Self-checking bench for spi_byte_frontend: a directed vector table, hand
// sequences for abort/reset/back-to-back/latency, and random frames checked
// against a slot-based transmit buffer model and an expected-byte queue.
module tb_spi_byte_frontend;
    import spi_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 50;
    localparam int LAT         = SYNC_STAGES + 2;

    logic       clk = 1'b0;
    logic       rst, sclk, mosi, cs_n, tx_load;
    logic [7:0] tx_data;
    logic       miso, rx_valid, rx_first, frame_start, frame_end, rx_abort;
    logic       tx_full, tx_underrun;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    spi_byte_frontend #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
        .frame_start(frame_start), .frame_end(frame_end), .rx_abort(rx_abort),
        .tx_data(tx_data), .tx_load(tx_load), .tx_full(tx_full), .tx_underrun(tx_underrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: record every pulse, sampled on the falling clk edge.
    logic [7:0] got_rx[$];
    logic       got_first[$];
    int n_start = 0, n_end = 0, n_abort = 0, n_abort_alone = 0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rx_valid) begin
                got_rx.push_back(rx_data);
                got_first.push_back(rx_first);
            end
            if (frame_start) n_start++;
            if (frame_end) n_end++;
            if (rx_abort) begin
                n_abort++;
                if (!frame_end) n_abort_alone++;
            end
        end
    end

    // Reference model state.
    logic       m_full = 1'b0;
    logic [7:0] m_buf  = 8'h00;
    logic [7:0] exp_rx[$];
    logic       exp_first[$];
    int exp_start = 0, exp_end = 0, exp_abort = 0;

    // Current frame description and results.
    int         f_len;
    logic       f_pre, f_noalign;
    logic [7:0] f_pre_val;
    logic [7:0] f_mo[4], f_lv[4], f_mi[4], e_mi[4];
    logic       f_ld[4], f_ur_mid[4], e_ur_mid[4];
    logic       e_ur_end, e_full_end;

    typedef struct {
        logic [7:0] mo;
        logic       pre;
        logic [7:0] pre_val;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] exp_mi;
        logic       exp_ur;
        logic       exp_full;
    } vec_t;
    vec_t vecs[6];

    task automatic clear_tracking();
        got_rx.delete(); got_first.delete(); exp_rx.delete(); exp_first.delete();
        n_start = 0; n_end = 0; n_abort = 0; n_abort_alone = 0;
        exp_start = 0; exp_end = 0; exp_abort = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clear_tracking();
        m_full = 1'b0;
    endtask

    task automatic pulse_load(input logic [7:0] v);
        @(posedge clk); #1;
        tx_data = v; tx_load = 1'b1;
        @(posedge clk); #1;
        tx_load = 1'b0;
    endtask

    // Each frame is a sequence of buffer "slots": one at frame start and one at
    // every completed-byte boundary, including the one after the last byte.
    // A slot takes the buffered byte if there is one, else sends 0x00 and
    // flags underrun. Loads made during byte b land in the buffer after slot b.
    task automatic model_frame();
        logic [7:0] v;
        logic ur;
        if (f_pre && !m_full) begin m_full = 1'b1; m_buf = f_pre_val; end
        ur = 1'b0;
        for (int b = 0; b <= f_len; b++) begin
            if (m_full) begin v = m_buf; m_full = 1'b0; end
            else begin v = 8'h00; ur = 1'b1; end
            if (b < f_len) begin
                e_mi[b] = v;
                e_ur_mid[b] = ur;
                exp_rx.push_back(f_mo[b]);
                exp_first.push_back(b == 0);
                if (f_ld[b] && !m_full) begin m_full = 1'b1; m_buf = f_lv[b]; end
            end
        end
        e_ur_end = ur;
        e_full_end = m_full;
        exp_start++;
        exp_end++;
    endtask

    task automatic xfer_byte(input int b);
        for (int i = 7; i >= 0; i--) begin
            mosi = f_mo[b][i];
            #HALF;
            f_mi[b][i] = miso;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
            if (i == 4) begin
                f_ur_mid[b] = tx_underrun;
                if (f_ld[b]) pulse_load(f_lv[b]);
            end
        end
    endtask

    task automatic run_frame(input int gap);
        if (f_pre) pulse_load(f_pre_val);
        else if (!f_noalign) begin @(posedge clk); #1; end
        cs_n = 1'b0;
        #HALF;
        for (int b = 0; b < f_len; b++) xfer_byte(b);
        #HALF;
        cs_n = 1'b1;
        #gap;
    endtask

    task automatic check_frame(input string tag);
        for (int b = 0; b < f_len; b++) begin
            check($sformatf("%s_miso%0d", tag, b), f_mi[b], e_mi[b]);
            check($sformatf("%s_urmid%0d", tag, b), f_ur_mid[b], e_ur_mid[b]);
        end
        check({tag, "_urend"}, tx_underrun, e_ur_end);
        check({tag, "_full"}, tx_full, e_full_end);
    endtask

    task automatic do_frame(input int gap, input string tag);
        model_frame();
        run_frame(gap);
        check_frame(tag);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_starts"}, n_start, exp_start);
        check({tag, "_ends"}, n_end, exp_end);
        check({tag, "_aborts"}, n_abort, exp_abort);
        check({tag, "_abort_alone"}, n_abort_alone, 0);
        check({tag, "_rx_count"}, got_rx.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++) begin
            check($sformatf("%s_rx%0d", tag, i), got_rx[i], exp_rx[i]);
            check($sformatf("%s_first%0d", tag, i), got_first[i], exp_first[i]);
        end
        clear_tracking();
    endtask

    task automatic set_single(input logic [7:0] mo, input logic pre, input logic [7:0] pv,
                              input logic ld, input logic [7:0] lv);
        f_len = 1; f_mo[0] = mo; f_pre = pre; f_pre_val = pv;
        f_ld[0] = ld; f_lv[0] = lv; f_noalign = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_miso"}, miso, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_rx_first"}, rx_first, 0);
        check({tag, "_tx_full"}, tx_full, 0);
        check({tag, "_tx_underrun"}, tx_underrun, 0);
        check({tag, "_pulses"}, n_start + n_end + n_abort + got_rx.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0] = '{8'h10, 1'b1, 8'hA5, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 8'h80, 1'b1, 8'h01, 8'h80, 1'b0, 1'b0};
        vecs[4] = '{8'h5A, 1'b0, 8'h00, 1'b1, 8'hC3, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 8'h7E, 1'b1, 8'h00, 8'h7E, 1'b0, 1'b0};

        cs_n = 1'b1;
        do_reset();
        repeat (20) @(posedge clk);
        #1 check_idle_outputs("reset_idle");

        // Directed single-byte vectors.
        for (int v = 0; v < 6; v++) begin
            set_single(vecs[v].mo, vecs[v].pre, vecs[v].pre_val, vecs[v].ld, vecs[v].lv);
            model_frame();
            run_frame(100);
            check($sformatf("vec%0d_miso", v), f_mi[0], vecs[v].exp_mi);
            check($sformatf("vec%0d_ur", v), tx_underrun, vecs[v].exp_ur);
            check($sformatf("vec%0d_full", v), tx_full, vecs[v].exp_full);
            check($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].mo);
            check_rx($sformatf("vec%0d", v));
        end

        // Command frame 10/01/00 with A5 preloaded and 3C loaded during byte 0.
        f_len = 3; f_noalign = 1'b0; f_pre = 1'b1; f_pre_val = 8'hA5;
        f_mo[0] = 8'h10; f_mo[1] = 8'h01; f_mo[2] = 8'h00;
        f_ld[0] = 1'b1; f_lv[0] = 8'h3C; f_ld[1] = 1'b0; f_ld[2] = 1'b0;
        do_frame(100, "cmd");
        check_rx("cmd");
        set_single(8'h20, 1'b1, 8'h55, 1'b0, 8'h00);
        do_frame(100, "ur_clear");
        check_rx("ur_clear");

        // Abort after 5 bits of 0xFF, then a clean command byte.
        @(posedge clk); #1;
        cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1; #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
        end
        #HALF;
        cs_n = 1'b1;
        #100;
        if (m_full) m_full = 1'b0;
        exp_start++; exp_end++; exp_abort++;
        check_rx("abort");
        set_single(CMD_LOAD_A, 1'b0, 8'h00, 1'b0, 8'h00);
        do_frame(100, "post_abort");
        check_rx("post_abort");

        // Reset in the middle of a byte with cs_n held low.
        set_single(8'h00, 1'b1, 8'h99, 1'b0, 8'h00);
        pulse_load(8'h99);
        cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1; #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
        end
        do_reset();
        repeat (20) @(posedge clk);
        #1 check_idle_outputs("mid_reset");
        cs_n = 1'b1;
        #100;
        check("mid_reset_no_start", n_start, 0);
        set_single(CMD_LOAD_A, 1'b0, 8'h00, 1'b0, 8'h00);
        do_frame(100, "post_reset");
        check_rx("post_reset");

        // Back-to-back frames with cs_n high for only SYNC_STAGES+2 clk.
        f_len = 2; f_noalign = 1'b0; f_pre = 1'b1; f_pre_val = 8'h12;
        f_mo[0] = CMD_START; f_mo[1] = 8'h44; f_ld[0] = 1'b1; f_lv[0] = 8'h34; f_ld[1] = 1'b0;
        do_frame(LAT * 10, "b2b_a");
        f_len = 1; f_noalign = 1'b1; f_pre = 1'b0; f_mo[0] = CMD_READ; f_ld[0] = 1'b0;
        do_frame(100, "b2b_b");
        check_rx("b2b");

        // rx_valid latency from the first clk edge that sees bit 8 high.
        set_single(8'h3C, 1'b0, 8'h00, 1'b0, 8'h00);
        model_frame();
        @(posedge clk); #1;
        cs_n = 1'b0;
        #HALF;
        for (int i = 7; i >= 1; i--) begin
            mosi = f_mo[0][i]; #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
        end
        mosi = f_mo[0][0];
        #HALF;
        @(negedge clk);
        sclk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (rx_valid && lat == 0) lat = k;
        end
        check("latency", lat, LAT);
        check("latency_rx_data", rx_data, 8'h3C);
        #HALF sclk = 1'b0;
        #HALF cs_n = 1'b1;
        #100;
        check_rx("latency");

        // Random frames against the model.
        for (int r = 0; r < 12; r++) begin
            f_len = $urandom_range(1, 4);
            f_noalign = 1'b0;
            f_pre = 1'($urandom_range(0, 1));
            f_pre_val = 8'($urandom);
            for (int b = 0; b < 4; b++) begin
                f_mo[b] = 8'($urandom);
                f_ld[b] = ($urandom_range(0, 9) < 6);
                f_lv[b] = 8'($urandom);
            end
            do_frame(100, $sformatf("rnd%0d", r));
            check_rx($sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_byte_frontend.md
Name: spi_byte_frontend

Overview:
- SPI mode-0 slave front end. Sits directly upstream of the command-decode / matrix-load FSM.
- Oversamples raw sclk, mosi and cs_n in the system clock domain through synchronizers.
- Deserializes MSB-first bytes into single-cycle rx_valid pulses, with first-byte and frame-end markers so the decoder can separate command bytes from data bytes.
- Serializes a one-deep transmit buffer onto miso.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per raw SPI input; legal range 2..3.
- BYTE_W, 8, bits per SPI transfer; fixed at 8, exposed for the package constant only.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- sclk  input  1  raw SPI clock, asynchronous to clk
- mosi  input  1  raw SPI data in
- cs_n  input  1  raw SPI chip select, active-low
- miso  output  1  SPI data out, driven 0 when deselected (no tristate)
- rx_data  output  8  last completed received byte; held until the next byte completes
- rx_valid  output  1  one-clk pulse when rx_data updates
- rx_first  output  1  qualifies rx_valid: the byte is the first of the current frame (the command byte)
- frame_start  output  1  one-clk pulse on synchronized cs_n falling edge
- frame_end  output  1  one-clk pulse on synchronized cs_n rising edge
- rx_abort  output  1  one-clk pulse with frame_end if the frame ended mid-byte (bit count ≠ 0)
- tx_data  input  8  byte to transmit next
- tx_load  input  1  write tx_data into the tx buffer; ignored while tx_full=1
- tx_full  output  1  tx buffer occupied
- tx_underrun  output  1  sticky; set when a byte boundary finds the buffer empty; cleared by frame_start

Behaviour:
- Reset (async, rst=1): sync chains to idle (cs_n=1, sclk=0, mosi=0); FSM=IDLE; bit_cnt=0. All outputs 0 (miso, rx_data, rx_valid, rx_first, frame_start, frame_end, rx_abort, tx_full, tx_underrun).
- Edge detection: registered copy of the last sync stage; rise = sync & ~prev, fall = ~sync & prev.
- Input constraint: each sclk phase must last ≥ SYNC_STAGES+2 clk periods. Faster sclk is unsupported and is not detected.
- FSM state IDLE:
  - On cs_n fall: go to ACTIVE; bit_cnt=0; first_pending=1; frame_start pulse.
  - On the same cycle, load tx_shift from the buffer if tx_full, clearing tx_full; otherwise load 0x00 and set tx_underrun.
  - Drive miso from tx_shift[7] from the next cycle.
- FSM state ACTIVE:
  - sclk rise: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
  - On the rise where bit_cnt==7: next cycle rx_data = completed byte, rx_valid=1, rx_first=first_pending. Then bit_cnt=0 and first_pending=0.
  - sclk fall with bit_cnt≠0: tx_shift <<= 1.
  - sclk fall with bit_cnt==0 (byte boundary after a completed byte): reload tx_shift from the buffer, with the same underrun rule as frame start.
  - cs_n rise: go to IDLE; frame_end pulse; rx_abort pulse if bit_cnt≠0; partial rx_shift discarded, no rx_valid; bit_cnt=0; miso=0.
- Latency: rx_valid asserts exactly SYNC_STAGES+2 clk rising edges after the first clk edge that samples raw sclk high on bit 8.
- Simultaneous cs_n rise and sclk rise in the same sync cycle: cs_n wins, and the byte is aborted.
- tx_load on the same cycle as a buffer drain: the drain takes the old contents, then the new byte is accepted (tx_full stays 1).
- Events while rst=1 are ignored. Reset mid-frame forces IDLE; after rst deasserts, a still-low cs_n produces no frame_start until a new falling edge.
- Bit and frame state change only on synchronized edges, never on raw inputs.

Decomposition:
- Shared package spi_pkg:
  - SPI_BYTE_W=8
  - state enum {IDLE, ACTIVE}
  - command constants already used downstream: CMD_LOAD_A=8'h10, plus CMD_LOAD_B, CMD_START, CMD_READ.
- One natural sub-module: spi_sync_edge (SYNC_STAGES flop chain plus rise/fall detect), instantiated three times, once each for sclk, mosi and cs_n.

Test Plan:
- Reset then idle 20 clk: all outputs 0, miso=0, no pulses.
- Frame sending 0x10, 0x01, 0x00 (sclk half-period 50 ns, clk 10 ns):
  - frame_start once.
  - Three rx_valid pulses with rx_data 0x10, 0x01, 0x00.
  - rx_first=1 only on 0x10.
  - frame_end once, rx_abort=0.
- Preload tx 0xA5 and load 0x3C during byte 1: miso bits across two bytes read 1010_0101 then 0011_1100; tx_underrun=0. A third byte with no load reads 0x00 and sets tx_underrun, which clears at the next frame_start.
- Raise cs_n after 5 bits of 0xFF: no rx_valid; frame_end and rx_abort pulse together. The next frame's byte 0x10 arrives intact with rx_first=1.
- Pulse rst mid-byte (bit 3) with cs_n held low:
  - Outputs return to 0.
  - No frame_start until cs_n toggles high then low.
  - A subsequent 0x10 is received correctly.
- Back-to-back frames with cs_n high for only SYNC_STAGES+2 clk: both frame_end/frame_start pairs are seen, and rx_first=1 on each frame's first byte.
